// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm sounding controller: 1 Hz buzzer pattern, stop, snooze, auto-timeout
module alarm_ringer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int GUARD_SECS  = 60,
  parameter int MAX_SNOOZES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_1hz,
  input  logic Trigger,
  input  logic btn_stop,
  input  logic btn_snooze,
  output logic feedback,
  output logic ringing,
  output logic snoozing,
  output logic buzzer
);

  localparam int SEC_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam int GRD_W   = $clog2(GUARD_SECS + 1);
  localparam int SNZ_W   = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

  localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_SECS - 1);
  localparam logic [SEC_W-1:0] SNZ_LAST  = SEC_W'(SNOOZE_SECS - 1);
  localparam logic [GRD_W-1:0] GRD_MAX   = GRD_W'(GUARD_SECS);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [GRD_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [SNZ_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic             beep_phase_q, beep_phase_d;
  logic             guard_done;
  logic             finish;

  assign guard_done = (guard_cnt_q == GRD_MAX);

  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    guard_cnt_d  = guard_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    beep_phase_d = beep_phase_q;
    finish       = 1'b0;

    // Guard counts every tick outside IDLE, including one that causes a transition.
    if (state_q != ST_IDLE && tick_1hz && !guard_done) begin
      guard_cnt_d = guard_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (Trigger) begin
          state_d      = ST_RING;
          sec_cnt_d    = '0;
          guard_cnt_d  = '0;
          snooze_cnt_d = '0;
          beep_phase_d = 1'b1;
        end
      end
      ST_RING: begin
        if (btn_stop) begin
          finish = 1'b1;
        end else if (btn_snooze && snooze_cnt_q < SNZ_MAX) begin
          state_d      = ST_SNOOZE;
          sec_cnt_d    = '0;
          snooze_cnt_d = snooze_cnt_q + 1'b1;
        end else if (tick_1hz) begin
          if (sec_cnt_q == RING_LAST) begin
            finish = 1'b1;
          end else begin
            sec_cnt_d    = sec_cnt_q + 1'b1;
            beep_phase_d = ~beep_phase_q;
          end
        end
      end
      ST_SNOOZE: begin
        if (btn_stop) begin
          finish = 1'b1;
        end else if (tick_1hz) begin
          if (sec_cnt_q == SNZ_LAST) begin
            state_d      = ST_RING;
            sec_cnt_d    = '0;
            beep_phase_d = 1'b1;
          end else begin
            sec_cnt_d = sec_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (guard_done) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if (finish) begin
      state_d = guard_done ? ST_IDLE : ST_HOLD;
    end

    // Entering IDLE leaves every counter clean for the next alarm event.
    if (state_q != ST_IDLE && state_d == ST_IDLE) begin
      sec_cnt_d    = '0;
      guard_cnt_d  = '0;
      snooze_cnt_d = '0;
      beep_phase_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sec_cnt_q    <= '0;
      guard_cnt_q  <= '0;
      snooze_cnt_q <= '0;
      beep_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      guard_cnt_q  <= guard_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      beep_phase_q <= beep_phase_d;
    end
  end

  assign feedback = (state_q != ST_IDLE);
  assign ringing  = (state_q == ST_RING);
  assign snoozing = (state_q == ST_SNOOZE);
  assign buzzer   = ringing & beep_phase_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - directed bench for alarm_ringer (RING=4, SNOOZE=3, GUARD=6, MAX_SNOOZES=2)
module tb_alarm_ringer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_1hz = 1'b0;
  logic Trigger = 1'b0;
  logic btn_stop = 1'b0;
  logic btn_snooze = 1'b0;
  logic feedback, ringing, snoozing, buzzer;
  logic [3:0] outs;
  int checks = 0;
  int errors = 0;

  assign outs = {feedback, ringing, snoozing, buzzer};

  always #5 clk = ~clk;

  alarm_ringer #(
    .RING_SECS(4), .SNOOZE_SECS(3), .GUARD_SECS(6), .MAX_SNOOZES(2)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .Trigger(Trigger),
    .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .feedback(feedback), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  // Each stimulus task drives at a falling edge and returns at the falling edge after the active edge.
  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic stop, input logic snooze);
    @(negedge clk) begin btn_stop = stop; btn_snooze = snooze; end
    @(negedge clk) begin btn_stop = 1'b0; btn_snooze = 1'b0; end
  endtask

  task automatic trigger_pulse();
    @(negedge clk) Trigger = 1'b1;
    @(negedge clk);
    Trigger = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(2);
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL reset_outs: got %b expected 0000", outs);
    end
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_trigger_timeout();
    logic [3:0] exp_buz;
    exp_buz = 4'b0101;
    @(negedge clk) Trigger = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 4'b1101) begin
      errors++; $display("FAIL trig_ring: got %b expected 1101", outs);
    end
    Trigger = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (outs !== {3'b110, exp_buz[t]}) begin
        errors++; $display("FAIL beep_tick%0d: got %b expected %b", t, outs, {3'b110, exp_buz[t]});
      end
    end
    tick();
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL timeout_hold: got %b expected 1000", outs);
    end
    ticks(2);
    checks++;
    if (feedback !== 1'b1) begin
      errors++; $display("FAIL guard_tick6_fb: got %b expected 1", feedback);
    end
    cycles(2);
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL timeout_idle: got %b expected 0000", outs);
    end
  endtask

  task automatic test_stop_trigger_held();
    do_reset();
    @(negedge clk) Trigger = 1'b1;
    @(negedge clk);
    ticks(2);
    press(1'b1, 1'b0);
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL stop_hold: got %b expected 1000", outs);
    end
    ticks(3);
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL hold_no_retrig: got %b expected 1000", outs);
    end
    Trigger = 1'b0;
    tick();
    checks++;
    if (feedback !== 1'b1) begin
      errors++; $display("FAIL hold_tick6_fb: got %b expected 1", feedback);
    end
    cycles(2);
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL hold_idle: got %b expected 0000", outs);
    end
  endtask

  task automatic test_snooze_limit();
    do_reset();
    trigger_pulse();
    press(1'b0, 1'b1);
    checks++;
    if (outs !== 4'b1010) begin
      errors++; $display("FAIL snooze1: got %b expected 1010", outs);
    end
    ticks(2);
    checks++;
    if (outs !== 4'b1010) begin
      errors++; $display("FAIL snooze1_mid: got %b expected 1010", outs);
    end
    tick();
    checks++;
    if (outs !== 4'b1101) begin
      errors++; $display("FAIL snooze1_back: got %b expected 1101", outs);
    end
    press(1'b0, 1'b1);
    checks++;
    if (outs !== 4'b1010) begin
      errors++; $display("FAIL snooze2: got %b expected 1010", outs);
    end
    ticks(3);
    press(1'b0, 1'b1);
    checks++;
    if (outs !== 4'b1101) begin
      errors++; $display("FAIL snooze3_ignored: got %b expected 1101", outs);
    end
    ticks(3);
    checks++;
    if (ringing !== 1'b1) begin
      errors++; $display("FAIL ring_before_to: got %b expected 1", ringing);
    end
    tick();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL to_guard_done_idle: got %b expected 0000", outs);
    end
  endtask

  task automatic test_stop_snooze_collision();
    do_reset();
    trigger_pulse();
    press(1'b1, 1'b1);
    checks++;
    if (outs !== 4'b1000) begin
      errors++; $display("FAIL collision_outs: got %b expected 1000", outs);
    end
    checks++;
    if (dut.snooze_cnt_q !== 2'd0) begin
      errors++; $display("FAIL collision_snzcnt: got %0d expected 0", dut.snooze_cnt_q);
    end
    ticks(6);
    cycles(2);
  endtask

  task automatic test_cancel_after_guard();
    do_reset();
    trigger_pulse();
    ticks(3);
    press(1'b0, 1'b1);
    ticks(3);
    press(1'b0, 1'b1);
    checks++;
    if (outs !== 4'b1010) begin
      errors++; $display("FAIL cancel_pre: got %b expected 1010", outs);
    end
    press(1'b1, 1'b0);
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL cancel_idle: got %b expected 0000", outs);
    end
  endtask

  task automatic test_reset_mid_snooze();
    do_reset();
    trigger_pulse();
    press(1'b0, 1'b1);
    tick();
    do_reset();
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("FAIL reset_mid: got %b expected 0000", outs);
    end
    trigger_pulse();
    checks++;
    if (outs !== 4'b1101) begin
      errors++; $display("FAIL retrigger: got %b expected 1101", outs);
    end
    press(1'b0, 1'b1);
    ticks(3);
    press(1'b0, 1'b1);
    checks++;
    if (outs !== 4'b1010) begin
      errors++; $display("FAIL second_snooze_again: got %b expected 1010", outs);
    end
  endtask

  initial begin
    test_reset();
    test_trigger_timeout();
    test_stop_trigger_held();
    test_snooze_limit();
    test_stop_snooze_collision();
    test_cancel_after_guard();
    test_reset_mid_snooze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ringer.md
# alarm_ringer

Alarm sounding controller that sits directly downstream of the alarm comparator. It consumes the comparator's `Trigger`, drives the buzzer with a 1 Hz on/off pattern, and handles stop, snooze and auto-timeout. It returns `feedback` to the comparator so the alarm cannot retrigger while it is active or still inside the matching minute.

## Interface
Parameters:
- `RING_SECS`, default 60: seconds of ringing before auto-stop (≥1).
- `SNOOZE_SECS`, default 300: snooze length in seconds (≥1).
- `GUARD_SECS`, default 60: minimum seconds `feedback` stays high after the initial trigger (≥1).
- `MAX_SNOOZES`, default 3: snoozes allowed per alarm event (≥0).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; forces IDLE and clears all counters.
- `tick_1hz`  in  1: one-cycle strobe, once per second.
- `Trigger`  in  1: alarm match from the comparator (level).
- `btn_stop`  in  1: one-cycle pulse, debounced upstream.
- `btn_snooze`  in  1: one-cycle pulse, debounced upstream.
- `feedback`  out  1: to the comparator; high in every state except IDLE.
- `ringing`  out  1: high in RING.
- `snoozing`  out  1: high in SNOOZE.
- `buzzer`  out  1: `ringing` AND `beep_phase`.

## Operation
- **States:** IDLE, RING, SNOOZE, HOLD.
- **Registers:**
  - `state`
  - `sec_cnt`: width clog2(max(RING_SECS,SNOOZE_SECS)+1)
  - `guard_cnt`: width clog2(GUARD_SECS+1)
  - `snooze_cnt`: width clog2(MAX_SNOOZES+1)
  - `beep_phase`
- **Guard counter:**
  - `guard_cnt` increments on `tick_1hz` whenever state ≠ IDLE.
  - It saturates at GUARD_SECS.
  - `guard_done` = (`guard_cnt` == GUARD_SECS).
- **"Finish":** next state is IDLE if `guard_done`, else HOLD.
- **IDLE:**
  - `Trigger`=1 → RING.
  - On entry: `sec_cnt`=0, `guard_cnt`=0, `snooze_cnt`=0, `beep_phase`=1.
- **RING:**
  - `btn_stop` → finish.
  - Else `btn_snooze` with `snooze_cnt` < MAX_SNOOZES → SNOOZE; `sec_cnt`=0; `snooze_cnt`+1.
  - `btn_snooze` with `snooze_cnt` == MAX_SNOOZES is ignored.
  - Else `tick_1hz` with `sec_cnt` == RING_SECS-1 → finish (timeout).
  - Else `tick_1hz` → `sec_cnt`+1 and toggle `beep_phase`.
- **SNOOZE:**
  - `btn_stop` → finish (cancel).
  - `tick_1hz` with `sec_cnt` == SNOOZE_SECS-1 → RING; `sec_cnt`=0; `beep_phase`=1.
  - Else `tick_1hz` → `sec_cnt`+1.
  - `btn_snooze` is ignored.
- **HOLD:**
  - Stays until `guard_done`, then → IDLE.
  - `Trigger` and buttons are ignored.
- **Priority within a cycle:** `reset` > `btn_stop` > `btn_snooze` > `tick_1hz` expiry/count.
  - On any state transition, the counter reloads given above apply; the tick does not also advance `sec_cnt`.
  - `guard_cnt` still counts a tick that coincides with a transition out of a non-IDLE state.
- **Outputs:**
  - Decoded only from registered state and `beep_phase`; no combinational path from any input to any output.
- **Reset:**
  - All outputs are 0, all counters 0, state IDLE.
  - Reset mid-RING, SNOOZE or HOLD takes effect at the next edge with no residual state.

## Timing
- `Trigger` high at edge N (state IDLE) → `ringing`, `feedback`, `buzzer` are 1 after edge N.
- The comparator sees `feedback` and drops `Trigger` by edge N+2; this is harmless because the state is no longer IDLE.
- **Buzzer pattern:**
  - 1 from RING entry until the first tick.
  - Then alternates each tick: on 1 s / off 1 s.
- **Ring timeout:** exits on the RING_SECS-th tick after entry.
- **Snooze:** returns to RING on the SNOOZE_SECS-th tick after entry.
- **Button latency:** a button pulse at edge N changes the outputs after edge N.
- **Guard:**
  - `feedback` stays high for at least GUARD_SECS ticks after the initial trigger.
  - It falls the cycle after `guard_done` is reached in HOLD, or immediately on finish if `guard_done` is already set.

## Test plan
Bench parameters: RING_SECS=4, SNOOZE_SECS=3, GUARD_SECS=6, MAX_SNOOZES=2.
1. **Trigger and timeout:** reset, then `Trigger`=1 for 2 cycles → `ringing`=`feedback`=`buzzer`=1 next cycle. `buzzer` goes 0/1/0 on ticks 1–3. Tick 4 → HOLD, `ringing`=0, `feedback`=1. Tick 6 → IDLE, `feedback`=0.
2. **Stop with `Trigger` held:** `btn_stop` after 2 ticks with `Trigger` held 1 → HOLD; no re-entry to RING. IDLE is reached only after guard tick 6.
3. **Snooze limit:**
   - Snooze → `snoozing`=1, and 3 ticks later back to RING with `buzzer`=1.
   - Second snooze is accepted.
   - Third `btn_snooze` is ignored; the alarm keeps ringing until timeout.
4. **Stop/snooze collision:** `btn_stop` and `btn_snooze` in the same cycle during RING → stop wins; `snoozing` stays 0 and `snooze_cnt` is unchanged.
5. **Cancel after guard:** `btn_stop` during SNOOZE after guard tick 6 → IDLE directly; `feedback`=0 next cycle.
6. **Reset mid-operation:**
   - `reset` during SNOOZE → all outputs 0 next cycle.
   - A later `Trigger` → RING, and two snoozes are allowed again.
